imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory writer: the write-side counterpart to the processor's instruction fetch port. It accepts a length-prefixed byte stream over a valid/ready handshake and assembles bytes into 32-bit words. It writes each word into imem at consecutive addresses and holds the processor in reset until the image is complete. It sits between the host/UART byte source and the imem write port, alongside the processor in the top-level wrapper.

## Interface
Parameters:
- ADDR_W, 12, imem word-address width; capacity is 2**ADDR_W words.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clock, input, 1, the single clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low; 0 forces the reset state immediately.
- start, input, 1, single-cycle request to begin a load; honoured only in IDLE or DONE.
- in_valid, input, 1, byte-source data valid.
- in_data, input, 8, stream byte.
- in_ready, output, 1, loader can accept a byte this cycle.
- address_imem, output, ADDR_W, imem word address for the write.
- data, output, 32, word to write.
- wren, output, 1, imem write enable, one cycle per word.
- proc_hold, output, 1, high holds the processor in reset while loading.
- done, output, 1, high in DONE.
- err, output, 1, sticky error flag for the current load; cleared by the next start.

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM (macro only), DONE.
- A byte is accepted on a rising edge where in_valid && in_ready. in_ready = 1 only in LEN_LO, LEN_HI, DATA, and CSUM.
- IDLE/DONE on start: go to LEN_LO, set proc_hold = 1, clear err/done, and reset the address counter and checksum to 0.
- LEN_LO/LEN_HI: capture a 16-bit word count N, low byte first.
  - After LEN_HI: if N = 0, go to CSUM (macro) or DONE; else go to DATA.
- DATA: shift bytes into the word little-endian (first byte → data[7:0]). On the 4th byte go to WRITE.
- WRITE (1 cycle): wren = 1, address_imem = word index, data = assembled word.
  - Then the index increments and words_left decrements.
  - If words_left becomes 0, go to CSUM/DONE; else return to DATA.
- Overflow: words with index ≥ 2**ADDR_W are still consumed (WRITE visited, wren = 0), and err is set. The address does not wrap.
- DONE: proc_hold = 0, done = 1, in_ready = 0. Remains in DONE until start.
- start in any other state is ignored. Bytes presented while in_ready = 0 are not consumed.
- Reset mid-load: return to IDLE immediately. Words already written stay in imem. proc_hold = 0.

## Timing
- Reset values:
  - State IDLE.
  - in_ready, wren, proc_hold, done, err = 0.
  - address_imem = 0, data = 0.
- start sampled at edge t → in_ready = 1 and proc_hold = 1 from t+.
- 4th byte of a word accepted at edge k → wren = 1 for exactly the cycle k..k+1. address_imem and data are stable while wren = 1 and held until the next WRITE.
- Maximum throughput is 1 word per 5 cycles (4 accept cycles + 1 WRITE).
- done rises on the edge after the final accepted byte (the final WRITE, or the checksum byte).

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last data word, state CSUM accepts one byte.
  - It is compared against the XOR of all N*4 data bytes; a mismatch sets err.
  - The loader then goes to DONE in either case, and proc_hold still drops.
- Not defined: CSUM state and checksum logic are absent. DONE follows the last WRITE directly.

## Test plan
- Reset released, no start → all outputs 0, in_ready 0, and in_valid bytes ignored.
- start, then bytes 02 00, 78 56 34 12, EF BE AD DE → WRITE 0x12345678 @0 and 0xDEADBEEF @1. Each wren is one cycle, done = 1, proc_hold = 0, err = 0.
- N = 0 (bytes 00 00) → no wren, DONE the edge after LEN_HI (or after the checksum byte 00 with the macro).
- in_valid toggled every other cycle during the 2-word load → identical writes; in_ready held during gaps.
- Reset asserted after 1.5 words → immediate IDLE with outputs at reset values. Word 0 written, word 1 not. A new start reloads correctly.
- With the macro: checksum byte for {78 56 34 12} sent as 0x00 → err = 1, done = 1. Sent as the correct value 0x08 → err = 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time imem writer: length-prefixed byte stream -> 32-bit little-endian words at consecutive addresses.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address_imem,
  output logic [31:0]       data,
  output logic              wren,
  output logic              proc_hold,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE} state_t;
  localparam state_t END_STATE = CSUM;
`else
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE} state_t;
  localparam state_t END_STATE = DONE;
`endif

  state_t state;
  state_t next_state;

  logic [7:0]      len_lo;
  logic [15:0]     words_left;
  logic [ADDR_W:0] widx;
  logic [23:0]     shift_word;
  logic [1:0]      byte_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic        overflow;

  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, len_lo};
  // widx saturates at 2**ADDR_W, so its top bit marks every word past capacity.
  assign overflow = widx[ADDR_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    wren       = 1'b0;
    proc_hold  = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        proc_hold = 1'b0;
        if (start) next_state = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (accept) next_state = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (accept) next_state = (len_full == 16'd0) ? END_STATE : DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (accept && byte_cnt == 2'd3) next_state = WRITE;
      end
      WRITE: begin
        wren       = !overflow;
        next_state = (words_left == 16'd1) ? END_STATE : DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        in_ready = 1'b1;
        if (accept) next_state = DONE;
      end
`endif
      DONE: begin
        proc_hold = 1'b0;
        done      = 1'b1;
        if (start) next_state = LEN_LO;
      end
      default: begin
        proc_hold  = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_lo       <= 8'd0;
      words_left   <= 16'd0;
      widx         <= '0;
      shift_word   <= 24'd0;
      byte_cnt     <= 2'd0;
      address_imem <= '0;
      data         <= 32'd0;
      err          <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err      <= 1'b0;
            widx     <= '0;
            byte_cnt <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
          end
        end
        LEN_LO: begin
          if (accept) len_lo <= in_data;
        end
        LEN_HI: begin
          if (accept) words_left <= len_full;
        end
        DATA: begin
          if (accept) begin
            byte_cnt   <= byte_cnt + 2'd1;
            shift_word <= {in_data, shift_word[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= csum ^ in_data;
`endif
            // Output registers load only for in-range words so they hold the last real write.
            if (byte_cnt == 2'd3) begin
              if (overflow) begin
                err <= 1'b1;
              end else begin
                data         <= {in_data, shift_word};
                address_imem <= widx[ADDR_W-1:0];
              end
            end
          end
        end
        WRITE: begin
          words_left <= words_left - 16'd1;
          if (!overflow) widx <= widx + {{ADDR_W{1'b0}}, 1'b1};
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept && in_data != csum) err <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads plus hand sequences, with a write scoreboard.
module tb_imem_loader;
  localparam int ADDR_W = 2;
  localparam int CAP    = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic [ADDR_W-1:0] address_imem;
  logic [31:0]       data;
  logic              wren;
  logic              proc_hold;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .address_imem(address_imem), .data(data), .wren(wren),
    .proc_hold(proc_hold), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  typedef struct {
    int               n;
    logic [5:0][31:0] w;
    bit               gaps;
    bit               bad;
  } vec_t;

  wr_t  expq[$];
  vec_t vecs[6];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every wren cycle must match the next expected write.
  always @(negedge clock) begin
    if (wren === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%h@%0d expected=none", data, address_imem);
      end else begin
        wr_t e;
        e = expq.pop_front();
        if (address_imem !== e.a || data !== e.d) begin
          failures++;
          $display("FAIL write actual=%h@%0d expected=%h@%0d", data, address_imem, e.d, e.a);
        end
      end
    end
  end

  function automatic vec_t mk(input int n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] w4,
                              input bit gaps, input bit bad);
    vec_t v;
    v.n = n;
    v.w = {32'h0, w4, w3, w2, w1, w0};
    v.gaps = gaps;
    v.bad = bad;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int cnt;
    cnt = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    if (!in_ready) begin
      failures++;
      checks++;
      $display("FAIL byte_accept_timeout actual=in_ready_0 expected=in_ready_1 byte=%h", b);
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic gap(input bit check_ready, input string name);
    @(negedge clock);
    if (check_ready) chk(name, in_ready, 1);
  endtask

  task automatic pulse_start(input string name);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    chk({name, "_ready"}, in_ready, 1);
    chk({name, "_hold"}, proc_hold, 1);
    chk({name, "_done_low"}, done, 0);
    chk({name, "_err_low"}, err, 0);
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      @(negedge clock);
      c++;
    end
    chk({name, "_done"}, done, 1);
  endtask

  task automatic load(input string name, input int n, input logic [5:0][31:0] w,
                      input bit gaps, input bit bad, input bit exp_err);
    logic [7:0]  cs;
    logic [31:0] cur;
    cs = 8'd0;
    pulse_start(name);
    send_byte(n[7:0]);
    if (gaps) gap(1'b0, name);
    send_byte(n[15:8]);
    if (gaps) gap(1'b0, name);
    for (int i = 0; i < n; i++) begin
      cur = w[i];
      if (i < CAP) expq.push_back({i[ADDR_W-1:0], cur});
      for (int j = 0; j < 4; j++) begin
        send_byte(cur[8*j +: 8]);
        cs = cs ^ cur[8*j +: 8];
        if (gaps) gap(j < 3, {name, "_gap_ready"});
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs ^ (bad ? 8'h5A : 8'h00));
`endif
    wait_done(name);
    @(negedge clock);
    chk({name, "_hold_low"}, proc_hold, 0);
    chk({name, "_err"}, err, exp_err);
    chk({name, "_ready_low"}, in_ready, 0);
    chk({name, "_pending_writes"}, expq.size(), 0);
    if (n > 0) chk({name, "_last_addr"}, address_imem, (n < CAP) ? n - 1 : CAP - 1);
  endtask

  initial begin
    vecs[0] = mk(2, 32'h12345678, 32'hDEADBEEF, 0, 0, 0, 1'b0, 1'b0);
    vecs[1] = mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    vecs[2] = mk(2, 32'h12345678, 32'hDEADBEEF, 0, 0, 0, 1'b1, 1'b0);
    vecs[3] = mk(1, 32'h12345678, 0, 0, 0, 0, 1'b0, 1'b1);
    vecs[4] = mk(1, 32'h12345678, 0, 0, 0, 0, 1'b0, 1'b0);
    vecs[5] = mk(5, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555,
                 1'b0, 1'b0);

    // Reset held, then released with no start.
    repeat (2) @(negedge clock);
    chk("rst_ready", in_ready, 0);
    chk("rst_wren", wren, 0);
    chk("rst_hold", proc_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", address_imem, 0);
    chk("rst_data", data, 0);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) begin
      @(negedge clock);
      chk("idle_ready", in_ready, 0);
      chk("idle_hold", proc_hold, 0);
      chk("idle_done", done, 0);
    end
    in_valid = 1'b0;

    for (int k = 0; k < 6; k++) begin
      load($sformatf("case%0d", k), vecs[k].n, vecs[k].w, vecs[k].gaps, vecs[k].bad,
           (vecs[k].n > CAP) || (CSUM_ON && vecs[k].bad));
    end

    // start during DATA must be ignored.
    pulse_start("midstart");
    send_byte(8'h01);
    send_byte(8'h00);
    expq.push_back({{ADDR_W{1'b0}}, 32'h12345678});
    send_byte(8'h78);
    send_byte(8'h56);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    send_byte(8'h34);
    send_byte(8'h12);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h08);
`endif
    wait_done("midstart");
    chk("midstart_err", err, 0);
    chk("midstart_pending", expq.size(), 0);

    // Reset after 1.5 words: word 0 written, word 1 dropped, then a clean reload.
    pulse_start("midrst");
    send_byte(8'h02);
    send_byte(8'h00);
    expq.push_back({{ADDR_W{1'b0}}, 32'h12345678});
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hEF);
    send_byte(8'hBE);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 0);
    chk("midrst_wren", wren, 0);
    chk("midrst_hold", proc_hold, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_addr", address_imem, 0);
    chk("midrst_data", data, 0);
    chk("midrst_pending", expq.size(), 0);
    @(negedge clock);
    reset = 1'b1;
    load("reload", 2, {32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h12345678}, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
